// File: rtl/input_debounce_bank_pkg.sv
// Shared definitions for the front-panel input conditioning bank.
// Channel map, default debounce window and the state encodings.
package input_debounce_bank_pkg;

    localparam int CH_START = 0;
    localparam int CH_RESET = 1;
    localparam int CH_SW0   = 2;

    // 10 ms at 50 MHz; the counter width must hold this value.
    localparam int DEFAULT_DB_CYCLES = 500_000;
    localparam int DEFAULT_CNT_W     = 19;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } bank_state_e;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } ch_state_e;

endpackage

// File: rtl/input_debounce_bank_channel.sv
// One input channel: two-flop synchroniser, stability counter and the
// STABLE/PENDING acceptance machine, plus the silent power-up priming.
module debounce_channel
    import input_debounce_bank_pkg::*;
#(
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset_signal,
    input  logic raw_i,
    input  logic run_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic primed_o
);

    // Acceptance happens on the cycle the count would reach DB_CYCLES,
    // so the stored count tops out at DB_CYCLES - 1 (assumes DB_CYCLES >= 2).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [1:0]       sync_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    ch_state_e        state_q,  state_d;
    logic             level_q,  level_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic             primed_q, primed_d;
    logic             syncLevel;

    assign syncLevel = sync_q[1];

    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            prev_q <= sync_q[1];
        end
    end

    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            state_q  <= STABLE;
            cnt_q    <= CNT_ZERO;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            primed_q <= primed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        primed_d = primed_q;

        if (!run_i) begin
            // Priming: learn the settled pin level without emitting edges.
            state_d = STABLE;
            if (primed_q) begin
                cnt_d = CNT_ZERO;
            end else if (syncLevel != prev_q) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
                level_d  = syncLevel;
                primed_d = 1'b1;
                cnt_d    = CNT_ZERO;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            case (state_q)
                STABLE: begin
                    cnt_d = CNT_ZERO;
                    if (syncLevel != level_q) begin
                        state_d = PENDING;
                        cnt_d   = CNT_ONE;
                    end
                end
                PENDING: begin
                    if (syncLevel == level_q) begin
                        state_d = STABLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE;
                        cnt_d   = CNT_ZERO;
                        level_d = syncLevel;
                        rise_d  = syncLevel;
                        fall_d  = ~syncLevel;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign primed_o = primed_q;

endmodule

// File: rtl/input_debounce_bank.sv
// Debounce bank for the front-panel pins: per-channel conditioning plus the
// global PRIME/RUN sequencing that gates edge reporting until all levels settle.
module input_debounce_bank
    import input_debounce_bank_pkg::*;
#(
    parameter int N_CH      = 9,
    parameter int DB_CYCLES = DEFAULT_DB_CYCLES,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic            clk,
    input  logic            reset_signal,
    input  logic [N_CH-1:0] raw_in_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic [N_CH-1:0] change_o,
    output logic            any_change_o,
    output logic            ready_o
);

    bank_state_e     state_q, state_d;
    logic [N_CH-1:0] primedVec;
    logic            runMode;

    assign runMode = (state_q == RUN);

    for (genvar g = 0; g < N_CH; g++) begin : gen_ch
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk          (clk),
            .reset_signal (reset_signal),
            .raw_i        (raw_in_i[g]),
            .run_i        (runMode),
            .level_o      (level_o[g]),
            .rise_o       (rise_o[g]),
            .fall_o       (fall_o[g]),
            .primed_o     (primedVec[g])
        );
    end

    always_ff @(posedge clk or posedge reset_signal) begin
        if (reset_signal) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave priming only once every channel has latched its settled level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIME:   if (&primedVec) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = PRIME;
        endcase
    end

    assign change_o     = rise_o | fall_o;
    assign any_change_o = |change_o;
    assign ready_o      = runMode;

endmodule

// File: tb/tb_input_debounce_bank.sv
// Directed bench for input_debounce_bank with DB_CYCLES = 8: expected edge
// events are queued when stimulus is driven and matched as the DUT pulses.
module tb_input_debounce_bank;

    localparam int N_CH      = 9;
    localparam int DB_CYCLES = 8;
    localparam int CNT_W     = 4;
    localparam int LATENCY   = 2 + DB_CYCLES;

    typedef struct {
        int              cycle;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
    } event_t;

    logic            clk = 1'b0;
    logic            reset_signal;
    logic [N_CH-1:0] rawIn;
    logic [N_CH-1:0] level, rise, fall, change;
    logic            anyChange, ready;

    int     cyc          = 0;
    int     nVectors     = 0;
    int     nMiscompares = 0;
    event_t sbQ[$];

    input_debounce_bank #(
        .N_CH      (N_CH),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .reset_signal (reset_signal),
        .raw_in_i     (rawIn),
        .level_o      (level),
        .rise_o       (rise),
        .fall_o       (fall),
        .change_o     (change),
        .any_change_o (anyChange),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        assert (observed === expected)
        else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_CH-1:0] value);
        @(negedge clk);
        rawIn = value;
    endtask

    task automatic expectEvent(input logic [N_CH-1:0] r, input logic [N_CH-1:0] f);
        event_t e;
        e.cycle = cyc + LATENCY;
        e.rise  = r;
        e.fall  = f;
        sbQ.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitReady(input string tag, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
        end
        checkOutput(tag, {31'd0, ready}, 32'd1);
    endtask

    // Scoreboard side: every pulse must match the oldest queued event.
    always @(negedge clk) begin
        event_t e;
        if (sbQ.size() > 0 && sbQ[0].cycle < cyc) begin
            checkOutput("event_overdue_cycle", cyc, sbQ[0].cycle);
            void'(sbQ.pop_front());
        end
        if (rise !== '0 || fall !== '0 || anyChange !== 1'b0) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_event", {14'd0, rise, fall}, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("event_cycle", cyc, e.cycle);
                checkOutput("event_rise", {23'd0, rise}, {23'd0, e.rise});
                checkOutput("event_fall", {23'd0, fall}, {23'd0, e.fall});
                checkOutput("event_change", {23'd0, change}, {23'd0, e.rise | e.fall});
                checkOutput("event_any_change", {31'd0, anyChange}, 32'd1);
            end
        end
    end

    initial begin
        logic [N_CH-1:0] v;

        // Reset with all pins low.
        reset_signal = 1'b1;
        rawIn        = '0;
        waitCycles(3);
        checkOutput("reset_level", {23'd0, level}, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_pulses", {14'd0, rise, fall}, 32'd0);
        reset_signal = 1'b0;
        waitReady("prime_low_ready_within_11", 11);
        checkOutput("prime_low_level", {23'd0, level}, 32'd0);

        // Start pin held high through reset: level learned silently.
        @(negedge clk);
        reset_signal = 1'b1;
        rawIn        = 9'h001;
        waitCycles(3);
        checkOutput("reset2_ready", {31'd0, ready}, 32'd0);
        reset_signal = 1'b0;
        waitReady("prime_high_ready", 12);
        checkOutput("prime_high_level", {23'd0, level}, 32'h001);

        // Clean rising edge on switch channel 4.
        v = 9'h011;
        applyStimulus(v);
        expectEvent(9'h010, 9'h000);
        waitCycles(LATENCY + 3);
        checkOutput("ch4_level_after_rise", {23'd0, level}, {23'd0, v});

        // Short 5-cycle pulse on channel 3 must be rejected.
        applyStimulus(v | 9'h008);
        waitCycles(4);
        applyStimulus(v);
        waitCycles(LATENCY + 5);
        checkOutput("ch3_glitch_level", {23'd0, level}, {23'd0, v});

        // Bouncing rise on channel 5 yields one event after the last toggle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? (v | 9'h020) : v);
            waitCycles(2);
        end
        v = v | 9'h020;
        applyStimulus(v);
        expectEvent(9'h020, 9'h000);
        waitCycles(LATENCY + 3);
        checkOutput("ch5_bounce_level", {23'd0, level}, {23'd0, v});

        // Simultaneous acceptance on channels 2 and 8.
        v = v | 9'h104;
        applyStimulus(v);
        expectEvent(9'h104, 9'h000);
        waitCycles(LATENCY + 3);
        checkOutput("ch2_ch8_level", {23'd0, level}, {23'd0, v});

        // Reset in the middle of a falling debounce on channel 2.
        v = v & ~9'h004;
        applyStimulus(v);
        waitCycles(4);
        reset_signal = 1'b1;
        #1;
        checkOutput("midreset_level", {23'd0, level}, 32'd0);
        checkOutput("midreset_ready", {31'd0, ready}, 32'd0);
        checkOutput("midreset_pulses", {14'd0, rise, fall}, 32'd0);
        waitCycles(3);
        reset_signal = 1'b0;
        waitReady("reprime_ready", 12);
        checkOutput("reprime_level", {23'd0, level}, {23'd0, v});

        // Falling edge on channel 4 after re-prime.
        v = v & ~9'h010;
        applyStimulus(v);
        expectEvent(9'h000, 9'h010);
        waitCycles(LATENCY + 3);
        checkOutput("ch4_level_after_fall", {23'd0, level}, {23'd0, v});

        waitCycles(DB_CYCLES + 5);
        checkOutput("scoreboard_drained", sbQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
